// File: rtl/pe_pkg.sv
// Shared definitions for the 8-requester priority encoder and arbiter.
package pe_pkg;

    localparam int NREQ = 8;
    localparam int IDXW = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Binary index to one-hot vector.
    function automatic logic [NREQ-1:0] idx_to_onehot(input logic [IDXW-1:0] idx);
        return NREQ'(1) << idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between the requesting agents and the arbiter.
// The release strobe is named rel because release is a reserved word.
interface rr_arbiter8_if;

    logic [pe_pkg::NREQ-1:0] req;
    logic                    mode;
    logic                    rel;
    logic [pe_pkg::NREQ-1:0] gnt;
    logic [pe_pkg::IDXW-1:0] gnt_idx;
    logic                    gnt_valid;
    logic                    timeout;

    modport master (
        output req, mode, rel,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, mode, rel,
        output gnt, gnt_idx, gnt_valid, timeout
    );

endinterface

// File: rtl/pe8x3_rot.sv
// Rotating 8-to-3 priority encoder: bit ptr has top priority, then ptr-1,
// wrapping down to ptr+1. With ptr=7 it is the plain highest-index-wins encoder.
module pe8x3_rot
    import pe_pkg::*;
(
    input  logic [NREQ-1:0] vec,
    input  logic [IDXW-1:0] ptr,
    output logic [IDXW-1:0] idx,
    output logic            valid
);

    logic [IDXW-1:0] pos;

    // Scan from lowest to highest priority so the last hit is the winner.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = ptr - IDXW'(k);
            if (vec[pos]) begin
                idx   = pos;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way arbiter with fixed or round-robin priority, grant holding,
// release handshake and a hold-time watchdog. All outputs are registered.
module rr_arbiter8
    import pe_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNTW     = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rr_arbiter8_if.slave   bus
);

    // Last counter value before the watchdog forces a release.
    localparam logic [CNTW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNTW'(MAX_HOLD - 1);

    state_e          state;
    logic [NREQ-1:0] gnt_q;
    logic [IDXW-1:0] idx_q;
    logic [IDXW-1:0] ptr_q;
    logic            valid_q;
    logic            timeout_q;
    logic [CNTW-1:0] hold_cnt;

    logic            owner_req;
    logic            wd_hit;
    logic            grant_end;
    logic            arb_now;
    logic [NREQ-1:0] arb_vec;
    logic [IDXW-1:0] arb_ptr;
    logic [IDXW-1:0] win_idx;
    logic            win_valid;

    // Decide whether this cycle arbitrates and what the encoder sees.
    always_comb begin
        owner_req = bus.req[idx_q];
        wd_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
        grant_end = (state == GRANT) && (bus.rel || !owner_req || wd_hit);
        arb_now   = (state == IDLE) || grant_end;
        // The outgoing owner is masked so a grant end always hands over.
        arb_vec   = (state == GRANT) ? (bus.req & ~idx_to_onehot(idx_q)) : bus.req;
        arb_ptr   = bus.mode ? ptr_q : IDXW'(NREQ - 1);
    end

    pe8x3_rot u_enc (
        .vec   (arb_vec),
        .ptr   (arb_ptr),
        .idx   (win_idx),
        .valid (win_valid)
    );

    // Controller FSM with grant registers, hold counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            gnt_q     <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            hold_cnt  <= '0;
            ptr_q     <= IDXW'(NREQ - 1);
        end else begin
            // Only a pure watchdog end raises timeout; release or a drop wins.
            timeout_q <= grant_end && wd_hit && !bus.rel && owner_req;
            if (arb_now) begin
                hold_cnt <= '0;
                if (win_valid) begin
                    state   <= GRANT;
                    gnt_q   <= idx_to_onehot(win_idx);
                    idx_q   <= win_idx;
                    valid_q <= 1'b1;
                    if (bus.mode) begin
                        ptr_q <= win_idx - IDXW'(1);
                    end
                end else begin
                    state   <= IDLE;
                    gnt_q   <= '0;
                    valid_q <= 1'b0;
                end
            end else if (MAX_HOLD != 0 && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + CNTW'(1);
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8 (MAX_HOLD=4): the driver queues the
// expected outputs for the edge it drives into, a negedge monitor compares.
module tb_rr_arbiter8;
    import pe_pkg::*;

    typedef struct {
        int         cyc;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
        int         tag;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   tag   = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    exp_t cur;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.MAX_HOLD(4), .CNTW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, want);
        end
    endtask

    // Apply inputs for the next edge and queue what must appear after it.
    task automatic step(input logic [7:0] r, input logic m, input logic rl,
                        input logic [7:0] eg, input logic [2:0] ei,
                        input logic ev, input logic et);
        exp_t e;
        bus.req  = r;
        bus.mode = m;
        bus.rel  = rl;
        tag++;
        e.cyc   = cyc + 1;
        e.gnt   = eg;
        e.idx   = ei;
        e.valid = ev;
        e.to    = et;
        e.tag   = tag;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation that is due at this sample point.
    always @(negedge clk) begin
        while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            cur = exp_q.pop_front();
            check($sformatf("step%0d gnt", cur.tag),       32'(bus.gnt),       32'(cur.gnt));
            check($sformatf("step%0d gnt_idx", cur.tag),   32'(bus.gnt_idx),   32'(cur.idx));
            check($sformatf("step%0d gnt_valid", cur.tag), 32'(bus.gnt_valid), 32'(cur.valid));
            check($sformatf("step%0d timeout", cur.tag),   32'(bus.timeout),   32'(cur.to));
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        bus.req  = '0;
        bus.mode = 1'b0;
        bus.rel  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset gnt",       32'(bus.gnt),       32'h0);
        check("reset gnt_idx",   32'(bus.gnt_idx),   32'h0);
        check("reset gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("reset timeout",   32'(bus.timeout),   32'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed priority with back-to-back handover on release.
        step(8'h26, 1'b0, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        step(8'h26, 1'b0, 1'b1, 8'h04, 3'd2, 1'b1, 1'b0);
        step(8'h06, 1'b0, 1'b1, 8'h02, 3'd1, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);

        // Round-robin with all requesting and release every cycle.
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] oh;
            oh = 8'h01 << i;
            step(8'hFF, 1'b1, 1'b1, oh, 3'(i), 1'b1, 1'b0);
        end
        step(8'hFF, 1'b1, 1'b1, 8'h80, 3'd7, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);

        // Watchdog hands over to requester 0.
        repeat (4) step(8'h81, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        step(8'h81, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 1'b1);
        step(8'h81, 1'b0, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        // Watchdog with a lone requester: idle one cycle, then re-grant.
        repeat (4) step(8'h80, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        step(8'h80, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0, 1'b1);
        step(8'h80, 1'b0, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 8'h00, 3'd7, 1'b0, 1'b0);

        // No preemption, owner drop handover, release coinciding with watchdog.
        step(8'h08, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        step(8'h48, 1'b0, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        repeat (4) step(8'h40, 1'b0, 1'b0, 8'h40, 3'd6, 1'b1, 1'b0);
        step(8'h40, 1'b0, 1'b1, 8'h00, 3'd6, 1'b0, 1'b0);

        // Move the round-robin pointer to 0, then hold a fixed-mode grant.
        step(8'h02, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        step(8'h00, 1'b0, 1'b0, 8'h00, 3'd1, 1'b0, 1'b0);
        step(8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        step(8'h10, 1'b0, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("async gnt",       32'(bus.gnt),       32'h0);
        check("async gnt_idx",   32'(bus.gnt_idx),   32'h0);
        check("async gnt_valid", 32'(bus.gnt_valid), 32'h0);
        check("async timeout",   32'(bus.timeout),   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Pointer is back at 7: requester 1 first, then 0.
        step(8'h03, 1'b1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        step(8'h03, 1'b1, 1'b1, 8'h01, 3'd0, 1'b1, 1'b0);
        step(8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("drain pending", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
